// File: rtl/pipe_skid_if.sv
// rtl/pipe_skid_if.sv - valid/ready stream carrying an instruction, its pc and pc increment
interface pipe_skid_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) ();
    logic            valid;
    logic            ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcinc;

    modport master (output valid, output instr, output pc, output pcinc, input ready);
    modport slave  (input valid, input instr, input pc, input pcinc, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry pipeline skid register with flush and registered in_ready
module pipe_skid_reg #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    pipe_skid_if.slave   in_if,
    pipe_skid_if.master  out_if,
    output logic [1:0]   occupancy
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state;
    logic [ILEN-1:0] main_instr, skid_instr;
    logic [XLEN-1:0] main_pc, skid_pc;
    logic [XLEN-1:0] main_pcinc, skid_pcinc;
    logic            in_xfer, out_xfer;

    // Handshake decodes come from state only, so out_ready never reaches in_ready.
    assign in_if.ready   = (state != TWO);
    assign out_if.valid  = (state != EMPTY);
    assign occupancy     = state;
    assign in_xfer       = in_if.valid && in_if.ready;
    assign out_xfer      = out_if.valid && out_if.ready;

    assign out_if.instr  = out_if.valid ? main_instr : NOP_INSTR;
    assign out_if.pc     = out_if.valid ? main_pc    : '0;
    assign out_if.pcinc  = out_if.valid ? main_pcinc : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            main_pcinc <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_pcinc <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_instr <= in_if.instr;
                        main_pc    <= in_if.pc;
                        main_pcinc <= in_if.pcinc;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_instr <= in_if.instr;
                        main_pc    <= in_if.pc;
                        main_pcinc <= in_if.pcinc;
                    end else if (in_xfer) begin
                        skid_instr <= in_if.instr;
                        skid_pc    <= in_if.pc;
                        skid_pcinc <= in_if.pcinc;
                        state      <= TWO;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_instr <= skid_instr;
                        main_pc    <= skid_pc;
                        main_pcinc <= skid_pcinc;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg against a depth-2 FIFO model
module tb_pipe_skid_reg;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcinc;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       flush_b;
    logic [1:0] occ;
    logic [1:0] occ_b;

    int    cmp_n = 0;
    int    err_n = 0;
    bit    mon_en = 1'b0;
    bit    mdl_in_ready = 1'b1;
    item_t exp_q[$];

    pipe_skid_if #(.XLEN(32), .ILEN(32)) a_in ();
    pipe_skid_if #(.XLEN(32), .ILEN(32)) a_out ();
    pipe_skid_if #(.XLEN(64), .ILEN(32)) b_in ();
    pipe_skid_if #(.XLEN(64), .ILEN(32)) b_out ();

    pipe_skid_reg #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h00000013)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_if     (a_in),
        .out_if    (a_out),
        .occupancy (occ)
    );

    pipe_skid_reg #(.XLEN(64), .ILEN(32), .NOP_INSTR(32'h00000001)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_b),
        .in_if     (b_in),
        .out_if    (b_out),
        .occupancy (occ_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two accepted items, cleared by flush or reset.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic int sz = exp_q.size();
            check("occupancy", 64'(occ), 64'(sz));
            check("in_ready", 64'(a_in.ready), 64'(sz < 2));
            check("out_valid", 64'(a_out.valid), 64'(sz > 0));
            if (sz > 0) begin
                check("out_instr", 64'(a_out.instr), 64'(exp_q[0].instr));
                check("out_pc", 64'(a_out.pc), 64'(exp_q[0].pc));
                check("out_pcinc", 64'(a_out.pcinc), 64'(exp_q[0].pcinc));
                if (a_out.ready) void'(exp_q.pop_front());
            end else begin
                check("idle_instr", 64'(a_out.instr), 64'h13);
                check("idle_pc", 64'(a_out.pc), 64'h0);
                check("idle_pcinc", 64'(a_out.pcinc), 64'h0);
            end
            mdl_in_ready = (sz < 2);
        end
    end

    always @(posedge clk) begin
        if (mon_en) begin
            if (flush) begin
                exp_q.delete();
            end else if (a_in.valid && mdl_in_ready) begin
                automatic item_t it;
                it.instr = a_in.instr;
                it.pc    = a_in.pc;
                it.pcinc = a_in.pcinc;
                exp_q.push_back(it);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        a_in.valid  = v;
        a_in.pc     = pc;
        a_in.pcinc  = pc + 32'd4;
        a_in.instr  = $urandom;
        a_out.ready = ordy;
        flush       = fl;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        flush_b     = 1'b0;
        a_in.valid  = 1'b1;
        a_in.pc     = 32'h99;
        a_in.pcinc  = 32'h9d;
        a_in.instr  = 32'hdead_beef;
        a_out.ready = 1'b0;
        b_in.valid  = 1'b0;
        b_in.pc     = '0;
        b_in.pcinc  = '0;
        b_in.instr  = '0;
        b_out.ready = 1'b1;

        // Reset holds everything idle even with a valid input across an edge.
        #1;
        check("rst_valid_pre_clk", 64'(a_out.valid), 64'h0);
        @(posedge clk);
        #1;
        check("rst_occ", 64'(occ), 64'h0);
        check("rst_in_ready", 64'(a_in.ready), 64'h1);
        check("rst_instr", 64'(a_out.instr), 64'h13);
        check("rst_pc", 64'(a_out.pc), 64'h0);
        check("rst_nop64", 64'(b_out.instr), 64'h1);
        a_in.valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Stream with out_ready held high.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure into TWO, an attempted third input, then drain.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        drive(1'b1, 32'h18, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush in TWO with an offered input, then flush in ONE with both transfers.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        drive(1'b1, 32'h20, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        drive(1'b1, 32'h34, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous transfers in ONE.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h50 + 32'(i * 4), 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // 64-bit instance passes a wide pc untouched.
        @(posedge clk);
        #1;
        b_in.valid = 1'b1;
        b_in.pc    = 64'hFFFF_FFFF_0000_0004;
        b_in.pcinc = 64'hFFFF_FFFF_0000_0008;
        b_in.instr = 32'h0000_0033;
        @(posedge clk);
        #1;
        b_in.valid = 1'b0;
        @(negedge clk);
        check("w64_valid", 64'(b_out.valid), 64'h1);
        check("w64_pc", b_out.pc, 64'hFFFF_FFFF_0000_0004);
        check("w64_pcinc", b_out.pcinc, 64'hFFFF_FFFF_0000_0008);
        @(negedge clk);
        check("w64_idle_instr", 64'(b_out.instr), 64'h1);

        // Asynchronous reset between edges while holding two entries.
        drive(1'b1, 32'h60, 1'b0, 1'b0);
        drive(1'b1, 32'h64, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        check("pre_rst_occ", 64'(occ), 64'h2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_valid", 64'(a_out.valid), 64'h0);
        check("arst_occ", 64'(occ), 64'h0);
        check("arst_in_ready", 64'(a_in.ready), 64'h1);
        check("arst_instr", 64'(a_out.instr), 64'h13);
        check("arst_pc", 64'(a_out.pc), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mdl_in_ready = 1'b1;
        mon_en = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the pc and pcInc payload fields.
REQ-002 Parameter ILEN, default 32, SHALL set the width of the instruction payload field.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, SHALL set the instruction value presented when the output holds no valid entry.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 flush  in  1  SHALL be a synchronous request to discard all held entries.
REQ-007 in_valid  in  1  SHALL mark the producer payload as valid.
REQ-008 in_ready  out  1  SHALL indicate the block accepts a payload this cycle.
REQ-009 in_instr  in  ILEN, in_pc  in  XLEN, in_pcinc  in  XLEN  SHALL be the producer payload.
REQ-010 out_valid  out  1  SHALL mark the output payload as valid.
REQ-011 out_ready  in  1  SHALL indicate the consumer takes the output payload this cycle.
REQ-012 out_instr  out  ILEN, out_pc  out  XLEN, out_pcinc  out  XLEN  SHALL be the output payload.
REQ-013 occupancy  out  2  SHALL report the number of held entries (0, 1 or 2).

Function
REQ-014 Storage SHALL be one main entry and one skid entry; state machine SHALL have states EMPTY, ONE and TWO.
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO; the output payload SHALL always be the main entry.
REQ-018 With out_valid = 0, out_instr SHALL equal NOP_INSTR and out_pc = out_pcinc = 0.
REQ-019 EMPTY: input transfer -> ONE, main loads the input; otherwise stay EMPTY.
REQ-020 ONE with both transfers: stay ONE, main loads the input.
REQ-021 ONE with input transfer only: -> TWO, skid loads the input, main holds.
REQ-022 ONE with output transfer only: -> EMPTY.
REQ-023 TWO with output transfer: -> ONE, main loads skid; otherwise stay TWO with both entries held.
REQ-024 Minimum latency SHALL be 1 cycle: a payload accepted in cycle N SHALL appear on the output with out_valid = 1 in cycle N+1 when the block was EMPTY, or ONE with an output transfer in cycle N.
REQ-025 While out_valid && !out_ready, the output payload SHALL remain bit-stable.
REQ-026 Ordering SHALL be strict FIFO; no payload is dropped or duplicated except by flush.
REQ-027 flush SHALL have priority over all transfers: next state EMPTY, and any same-cycle input SHALL be discarded even if in_ready = 1.
REQ-028 After flush, the next cycle SHALL present out_valid = 0, NOP_INSTR, in_ready = 1 and occupancy = 0.
REQ-029 An output transfer in a flush cycle SHALL count as consumed by the consumer; the block takes no further action on it.
REQ-030 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.

Reset
REQ-031 While rst_n = 0, the state SHALL be EMPTY and both entries cleared (instr = NOP_INSTR, pc = pcinc = 0), independent of clk.
REQ-032 During reset, outputs SHALL be out_valid = 0, out_instr = NOP_INSTR, out_pc = out_pcinc = 0, occupancy = 0 and in_ready = 1, and inputs SHALL be ignored.
REQ-033 Reset asserted mid-operation SHALL discard all held entries immediately; the first edge after release SHALL behave as EMPTY.

Verification
REQ-034 Stream: out_ready = 1, in_valid = 1 for 4 cycles with pc 0x0, 0x4, 0x8, 0xC -> outputs appear one cycle later in order, in_ready stays 1, occupancy stays 1.
REQ-035 Backpressure: block in ONE holding pc 0x10, out_ready = 0, input pc 0x14 accepted -> TWO, in_ready = 0, out_pc holds 0x10; then out_ready = 1 -> out_pc 0x10 then 0x14, no loss.
REQ-036 Flush in TWO with in_valid = 1 (pc 0x20) -> next cycle out_valid = 0, out_instr = 0x00000013, occupancy = 0, and pc 0x20 never appears.
REQ-037 Async reset: rst_n pulled low between edges while in TWO -> outputs go to reset values before the next edge; after release, one input (pc 0x40) appears one cycle later.
REQ-038 Simultaneous transfers in ONE, held for 3 cycles -> state stays ONE and each new payload replaces main with 1-cycle latency.
REQ-039 Parameter sweep: XLEN = 64 with NOP_INSTR = 32'h00000001 -> idle out_instr = 0x00000001, 64-bit pc 0xFFFF_FFFF_0000_0004 passes unchanged.
